rw_serial_tx: RTL and testbench



---
 rtl/rw_serial_pkg.sv | 19 +
 rtl/rw_serial_bitcnt.sv | 27 ++
 rtl/rw_serial_tx.sv | 140 ++++++++++++++
 tb/tb_rw_serial_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rw_serial_pkg.sv
// rtl/rw_serial_pkg.sv - shared types, line constants and frame sizing for the 1-bit device link
package rw_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    function automatic int frame_len(input int data_w, input int parity_en, input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/rw_serial_bitcnt.sv
// rtl/rw_serial_bitcnt.sv - loadable down-counter with terminal-count flag, shared by DATA and STOP phases
module rw_serial_bitcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/rw_serial_tx.sv
// rtl/rw_serial_tx.sv - framed bit-serial transmitter driving the ReWire device __in0 input
module rw_serial_tx
    import rw_serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              __out0,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(STOP_BITS - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic              r_parity;
    logic              w_parity_next;
    logic              r_out;
    logic              w_out_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_dec;
    logic              w_tc;
    logic              w_ready;
    logic              w_accept;

    rw_serial_bitcnt #(
        .W(CNT_W)
    ) u_bitcnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    // Ready in the last stop cycle lets the next frame start with no idle gap.
    assign w_ready  = !rst && ((r_state == IDLE) || ((r_state == STOP) && w_tc));
    assign w_accept = in_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_out    <= LINE_IDLE;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_out    <= w_out_next;
            r_busy   <= w_busy_next;
        end
    end

    // Outputs are computed for the next state so the line bit is registered with it.
    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_out_next    = r_out;
        w_load        = 1'b0;
        w_load_val    = '0;
        w_dec         = 1'b0;

        case (r_state)
            IDLE: begin
                w_out_next = LINE_IDLE;
            end
            START: begin
                w_state_next = DATA;
                w_out_next   = r_shift[0];
                w_shift_next = r_shift >> 1;
                w_load       = 1'b1;
                w_load_val   = DATA_LOAD;
            end
            DATA: begin
                if (!w_tc) begin
                    w_out_next   = r_shift[0];
                    w_shift_next = r_shift >> 1;
                    w_dec        = 1'b1;
                end else if (PARITY_EN != 0) begin
                    w_state_next = PARITY;
                    w_out_next   = r_parity;
                end else begin
                    w_state_next = STOP;
                    w_out_next   = LINE_IDLE;
                    w_load       = 1'b1;
                    w_load_val   = STOP_LOAD;
                end
            end
            PARITY: begin
                w_state_next = STOP;
                w_out_next   = LINE_IDLE;
                w_load       = 1'b1;
                w_load_val   = STOP_LOAD;
            end
            STOP: begin
                w_out_next = LINE_IDLE;
                if (!w_tc) begin
                    w_dec = 1'b1;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_out_next   = LINE_IDLE;
            end
        endcase

        if (w_accept) begin
            w_state_next  = START;
            w_shift_next  = in_data;
            w_parity_next = ^in_data;
            w_out_next    = START_BIT;
        end

        w_busy_next = (w_state_next != IDLE);
    end

    assign in_ready = w_ready;
    assign __out0   = r_out;
    assign busy     = r_busy;

endmodule

// File: tb/tb_rw_serial_tx.sv
// tb/tb_rw_serial_tx.sv - directed table-driven bench for rw_serial_tx (default and 4-bit/no-parity/2-stop builds)
module tb_rw_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out0;
    logic       busy;

    logic       in_valid4;
    logic [3:0] in_data4;
    logic       in_ready4;
    logic       out04;
    logic       busy4;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    rw_serial_tx dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .__out0   (out0),
        .busy     (busy)
    );

    rw_serial_tx #(
        .DATA_W    (4),
        .PARITY_EN (0),
        .STOP_BITS (2)
    ) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid4),
        .in_data  (in_data4),
        .in_ready (in_ready4),
        .__out0   (out04),
        .busy     (busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, " idle out"}, out0, 1'b1);
        chk({nm, " idle busy"}, busy, 1'b0);
        chk({nm, " idle ready"}, in_ready, 1'b1);
    endtask

    task automatic send_frame(input string nm, input logic [7:0] d, input logic [10:0] f,
                              input logic toggle);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s bit%0d", nm, i), out0, f[i]);
            chk($sformatf("%s busy%0d", nm, i), busy, 1'b1);
            chk($sformatf("%s ready%0d", nm, i), in_ready, (i == 10));
            if (toggle) in_data = ~in_data;
            tick();
        end
        check_idle(nm);
    endtask

    initial begin
        logic [10:0] f0;
        logic [10:0] f1;
        logic [6:0]  f4;

        vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
        vecs[1] = '{8'h01, 11'b1_1_00000001_0};
        vecs[2] = '{8'h7E, 11'b1_0_01111110_0};
        vecs[3] = '{8'h80, 11'b1_1_10000000_0};
        vecs[4] = '{8'hC4, 11'b1_1_11000100_0};
        vecs[5] = '{8'h3C, 11'b1_0_00111100_0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_valid4 = 1'b0;
        in_data4  = 4'h0;
        tick();
        tick();
        chk("reset ready forced low", in_ready, 1'b0);
        chk("reset out", out0, 1'b1);
        chk("reset busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check_idle("after reset");

        for (int v = 0; v < 6; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].frame, 1'b0);
            tick();
        end

        // Back-to-back 0x00 then 0xFF with in_valid held high.
        f0 = 11'b1_0_00000000_0;
        f1 = 11'b1_0_11111111_0;
        in_valid = 1'b1;
        in_data  = 8'h00;
        tick();
        in_data = 8'hFF;
        for (int k = 0; k < 22; k++) begin
            if (k == 11) in_valid = 1'b0;
            chk($sformatf("b2b bit%0d", k), out0, (k < 11) ? f0[k] : f1[k - 11]);
            chk($sformatf("b2b busy%0d", k), busy, 1'b1);
            chk($sformatf("b2b ready%0d", k), in_ready, (k == 10) || (k == 21));
            tick();
        end
        check_idle("b2b");

        // in_data churns while not ready; only the accepted word goes out, once.
        send_frame("toggle", 8'h5B, 11'b1_1_01011011_0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("toggle extra out%0d", i), out0, 1'b1);
            chk($sformatf("toggle extra busy%0d", i), busy, 1'b0);
        end

        // Reset during payload bit 3 of 0x3C.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort pre bit3", out0, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort ready during rst", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_idle("abort");
        send_frame("after abort", 8'h81, 11'b1_0_10000001_0, 1'b0);

        // Reset and in_valid together: nothing accepted.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #1;
        chk("rst+valid ready", in_ready, 1'b0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst+valid out%0d", i), out0, 1'b1);
            chk($sformatf("rst+valid busy%0d", i), busy, 1'b0);
            tick();
        end

        // 4-bit, no parity, two stop bits.
        f4 = 7'b1_1_1001_0;
        in_valid4 = 1'b1;
        in_data4  = 4'h9;
        tick();
        in_valid4 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("w4 bit%0d", i), out04, f4[i]);
            chk($sformatf("w4 busy%0d", i), busy4, 1'b1);
            chk($sformatf("w4 ready%0d", i), in_ready4, (i == 6));
            tick();
        end
        chk("w4 idle out", out04, 1'b1);
        chk("w4 idle busy", busy4, 1'b0);
        chk("w4 idle ready", in_ready4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
